ip_header_gen_wide: RTL and testbench
=====================================

Name: ip_header_gen_wide

Overview:
- Parametrised IPv4 header generator: emits a 20-byte option-less IPv4 header on an AXI-stream of configurable width.
- Header fields are latched once per packet; the checksum is computed by an internal pipelined FSM, with no joiner/broadcaster network.
- Adds a configurable TTL and flags field, a rolling identification counter, and total-length overflow detection.
- Sits in front of the payload joiner in the UDP/IP transmit path.

Parameters:
- AXIS_BYTES, 1, output bytes per beat; must divide 20 (1, 2, 4, 5, 10, 20); elaboration error otherwise.
- TTL, 8'd64, time-to-live field value.
- FLAGS_FRAG, 16'h4000, flags plus fragment-offset word (default: DF set).
- ID_INIT, 16'h0000, identification value after reset.

Ports:
- clk  in  1  clock.
- sresetn  in  1  synchronous active-low reset.
- src_ip  in  32  source address; sampled at length handshake.
- dest_ip  in  32  destination address; sampled at length handshake.
- protocol  in  8  protocol number; sampled at length handshake.
- payload_length_axis_tready  out  1  length accept.
- payload_length_axis_tvalid  in  1  length valid.
- payload_length_axis_tlast  in  1  ignored.
- payload_length_axis_tdata  in  16  payload bytes, excluding header.
- axis_o_tready  in  1  downstream ready.
- axis_o_tvalid  out  1  header beat valid.
- axis_o_tlast  out  1  final header beat.
- axis_o_tdata  out  8*AXIS_BYTES  header bytes, MSB-first (first byte in top byte lane).
- len_err  out  1  one-cycle pulse: length request dropped.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, sresetn).
- Reset values: all outputs 0 (tready, tvalid, tlast, tdata, len_err); state IDLE; beat counter 0; ID register = ID_INIT.
- FSM states: IDLE, SUM, FOLD, SEND.
- IDLE:
  - payload_length_axis_tready = 1; tready is 0 in every other state.
  - On handshake at cycle T, compute total = payload + 20 at 17-bit width.
  - If total > 65535: pulse len_err at T+1, stay in IDLE, no header emitted, ID unchanged.
  - Otherwise: latch total[15:0], src_ip, dest_ip, protocol and the current ID; go to SUM.
- SUM (T+1): register a 20-bit sum of the nine non-checksum 16-bit header words (checksum word taken as 0).
- FOLD (T+2):
  - Fold carries twice: s = sum[15:0] + sum[19:16]; s = s[15:0] + s[16].
  - Register checksum = ~s[15:0]. Go to SEND.
- SEND:
  - axis_o_tvalid = 1 from T+3; first beat is registered.
  - Header byte order: 45 00 | total | ID | FLAGS_FRAG | TTL proto | checksum | src_ip | dest_ip.
  - Beat k carries bytes k*AXIS_BYTES .. k*AXIS_BYTES+AXIS_BYTES-1.
  - tdata and tlast are held stable while tvalid && !tready.
  - Beat counter advances only on handshake.
  - tlast = 1 on beat 20/AXIS_BYTES-1.
  - On the last handshake: tvalid falls next cycle, counter clears, ID updates (see optional feature), return to IDLE.
- Minimum spacing: 3 idle cycles between the last header beat and the next header's first beat; lengths are never accepted during SUM, FOLD or SEND.
- Input changes: src_ip, dest_ip and protocol changes after the handshake do not affect the in-flight header.
- Reset mid-operation: everything returns to reset values on the next edge; a partially sent header is abandoned, with no tlast.
- ID wraps 16'hFFFF -> 16'h0000.

Optional Feature:
- Macro: IP_HEADER_GEN_ID_COUNTER_EN.
- Defined: identification increments by 1 after each fully transmitted header (not on len_err, not on reset abort).
- Undefined: identification is constantly ID_INIT; the counter register is removed.

Decomposition:
- Package ip_pkg holds:
  - IP_HEADER_BYTES = 20, IP_VERSION_IHL = 8'h45, IP_TOS = 8'h00.
  - Typedef ipv4_addr_t (logic [31:0]).
  - Typedef ipv4_hdr_t: packed struct in wire order.
  - Function ip_csum_fold.
- Sub-module ip_checksum_calc (SUM/FOLD pipeline, 2-cycle latency, hold-when-stalled) is natural and reusable by a future RX checker.

Test Plan:
- Known-vector check:
  - Stimulus: AXIS_BYTES=1, ID_INIT=0, src c0a80001, dst c0a800c7, proto 11, length 95, tready=1.
  - Response: bytes 45 00 00 73 00 00 40 00 40 11 b8 61 c0 a8 00 01 c0 a8 00 c7; tlast on byte 20; first tvalid exactly 3 cycles after handshake.
- AXIS_BYTES=4, same inputs:
  - Response: 5 beats, 45000073 / 00004000 / 4011b861 / c0a80001 / c0a800c7; tlast on beat 5.
- Random tready deassertion (~50%):
  - Response: tdata/tlast stable while stalled; byte sequence identical to the stall-free run.
- Boundary lengths:
  - Length 65515: total ffff emitted.
  - Length 65516: len_err pulse, no tvalid, ID unchanged, tready back high next cycle.
- With IP_HEADER_GEN_ID_COUNTER_EN, ID_INIT=fffe, three packets:
  - Response: IDs fffe, ffff, 0000; checksums recomputed correctly each time. Without the macro, all IDs are fffe.
- Reset mid-header:
  - Stimulus: sresetn low after beat 7.
  - Response: tvalid 0 next cycle; no tlast; next packet starts from byte 0 with ID = ID_INIT.

Source files
------------

// File: rtl/ip_pkg.sv
// Shared IPv4 definitions: header layout in wire order, FSM states and checksum fold.
package ip_pkg;

  localparam int         IP_HEADER_BYTES = 20;
  localparam logic [7:0] IP_VERSION_IHL  = 8'h45;
  localparam logic [7:0] IP_TOS          = 8'h00;

  typedef logic [31:0] ipv4_addr_t;

  typedef struct packed {
    logic [7:0]  version_ihl;
    logic [7:0]  tos;
    logic [15:0] total_len;
    logic [15:0] id;
    logic [15:0] flags_frag;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] checksum;
    ipv4_addr_t  src_ip;
    ipv4_addr_t  dest_ip;
  } ipv4_hdr_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SUM, ST_FOLD, ST_SEND} hdr_state_t;

  // Two carry folds are enough: nine 16-bit words never exceed 20 bits.
  function automatic logic [15:0] ip_csum_fold(input logic [19:0] sum);
    logic [16:0] s;
    s = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
    s = {1'b0, s[15:0]} + {16'd0, s[16]};
    return ~s[15:0];
  endfunction

endpackage

// File: rtl/ip_checksum_calc.sv
// Two-stage IPv4 header checksum: word sum, then carry fold and invert.
// Stages hold their contents while en is low so the result stays put downstream.
module ip_checksum_calc
  import ip_pkg::*;
(
  input  logic        clk,
  input  logic        en,
  input  ipv4_hdr_t   hdr,
  output logic [15:0] csum
);

  logic [19:0] sum_p0;
  logic [15:0] csum_p1;
  logic [15:0] unused_csum_field;

  assign unused_csum_field = hdr.checksum;

  function automatic logic [19:0] word_sum(input ipv4_hdr_t h);
    return {4'd0, h.version_ihl, h.tos} + {4'd0, h.total_len} + {4'd0, h.id}
         + {4'd0, h.flags_frag} + {4'd0, h.ttl, h.protocol}
         + {4'd0, h.src_ip[31:16]} + {4'd0, h.src_ip[15:0]}
         + {4'd0, h.dest_ip[31:16]} + {4'd0, h.dest_ip[15:0]};
  endfunction

  // Stage p0: raw 20-bit sum of the nine non-checksum words
  always_ff @(posedge clk) begin
    if (en) sum_p0 <= word_sum(hdr);
  end

  // Stage p1: folded, inverted checksum
  always_ff @(posedge clk) begin
    if (en) csum_p1 <= ip_csum_fold(sum_p0);
  end

  assign csum = csum_p1;

endmodule

// File: rtl/ip_header_gen_wide.sv
// IPv4 header generator: latches fields on a length handshake and streams a 20-byte header.
// Optional macro IP_HEADER_GEN_ID_COUNTER_EN enables a rolling identification counter.
module ip_header_gen_wide
  import ip_pkg::*;
#(
  parameter int          AXIS_BYTES = 1,
  parameter logic [7:0]  TTL        = 8'd64,
  parameter logic [15:0] FLAGS_FRAG = 16'h4000,
  parameter logic [15:0] ID_INIT    = 16'h0000
) (
  input  logic                    clk,
  input  logic                    sresetn,
  input  logic [31:0]             src_ip,
  input  logic [31:0]             dest_ip,
  input  logic [7:0]              protocol,
  output logic                    payload_length_axis_tready,
  input  logic                    payload_length_axis_tvalid,
  input  logic                    payload_length_axis_tlast,
  input  logic [15:0]             payload_length_axis_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic                    axis_o_tlast,
  output logic [8*AXIS_BYTES-1:0] axis_o_tdata,
  output logic                    len_err
);

  localparam int         BW        = 8 * AXIS_BYTES;
  localparam int         HDR_W     = 8 * IP_HEADER_BYTES;
  localparam int         NBEATS    = IP_HEADER_BYTES / AXIS_BYTES;
  localparam logic [4:0] LAST_BEAT = 5'(NBEATS - 1);

  generate
    if (IP_HEADER_BYTES % AXIS_BYTES != 0) begin : g_bad_axis_bytes
      $error("AXIS_BYTES must divide the 20-byte header");
    end
  endgenerate

  hdr_state_t  state;
  logic [4:0]  beat;
  ipv4_hdr_t   hdr_q;
  ipv4_hdr_t   hdr_tx;
  logic [15:0] csum;
  logic [15:0] cur_id;
  logic [16:0] total;
  logic        len_hs;
  logic        last_hs;
  logic [BW-1:0] beat_data;
  logic        unused_tlast;

  assign unused_tlast = payload_length_axis_tlast;
  assign total   = {1'b0, payload_length_axis_tdata} + 17'd20;
  assign len_hs  = (state == ST_IDLE) && payload_length_axis_tready && payload_length_axis_tvalid;
  assign last_hs = (state == ST_SEND) && axis_o_tready && (beat == LAST_BEAT);

`ifdef IP_HEADER_GEN_ID_COUNTER_EN
  logic [15:0] id_q;

  always_ff @(posedge clk) begin
    if (!sresetn)     id_q <= ID_INIT;
    else if (last_hs) id_q <= id_q + 16'd1;
  end

  assign cur_id = id_q;
`else
  assign cur_id = ID_INIT;
`endif

  // Header fields are captured once; later input changes cannot reach the in-flight header
  always_ff @(posedge clk) begin
    if (len_hs && !total[16]) begin
      hdr_q <= '{version_ihl: IP_VERSION_IHL, tos: IP_TOS, total_len: total[15:0],
                 id: cur_id, flags_frag: FLAGS_FRAG, ttl: TTL, protocol: protocol,
                 checksum: 16'd0, src_ip: src_ip, dest_ip: dest_ip};
    end
  end

  ip_checksum_calc u_csum (
    .clk  (clk),
    .en   ((state == ST_SUM) || (state == ST_FOLD)),
    .hdr  (hdr_q),
    .csum (csum)
  );

  always_comb begin
    hdr_tx          = hdr_q;
    hdr_tx.checksum = csum;
    beat_data       = '0;
    for (int k = 0; k < NBEATS; k++) begin
      if (beat == 5'(k)) beat_data = hdr_tx[HDR_W-1-k*BW -: BW];
    end
  end

  assign axis_o_tdata = axis_o_tvalid ? beat_data : '0;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state                      <= ST_IDLE;
      beat                       <= 5'd0;
      payload_length_axis_tready <= 1'b0;
      axis_o_tvalid              <= 1'b0;
      axis_o_tlast               <= 1'b0;
      len_err                    <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          payload_length_axis_tready <= 1'b1;
          if (len_hs) begin
            if (total[16]) begin
              len_err <= 1'b1;
            end else begin
              payload_length_axis_tready <= 1'b0;
              state                      <= ST_SUM;
            end
          end
        end
        ST_SUM: state <= ST_FOLD;
        ST_FOLD: begin
          state         <= ST_SEND;
          axis_o_tvalid <= 1'b1;
          axis_o_tlast  <= (LAST_BEAT == 5'd0);
        end
        ST_SEND: begin
          if (axis_o_tready) begin
            if (beat == LAST_BEAT) begin
              state                      <= ST_IDLE;
              beat                       <= 5'd0;
              axis_o_tvalid              <= 1'b0;
              axis_o_tlast               <= 1'b0;
              payload_length_axis_tready <= 1'b1;
            end else begin
              beat         <= beat + 5'd1;
              axis_o_tlast <= (beat + 5'd1 == LAST_BEAT);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_header_gen_wide.sv
// Scoreboard bench for ip_header_gen_wide: byte-wide DUT (with stalls) and 4-byte DUT side by side.
`timescale 1ns/1ps
module tb_ip_header_gen_wide;

`ifdef IP_HEADER_GEN_ID_COUNTER_EN
  localparam logic [15:0] ID0 = 16'hfffe;
`else
  localparam logic [15:0] ID0 = 16'h0000;
`endif

  // Hand-computed header for len 95, c0a80001 -> c0a800c7, proto 0x11, ID 0
  localparam logic [159:0] KV = 160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7;

  logic        clk = 1'b0;
  logic        sresetn = 1'b0;
  logic [31:0] src_ip = '0, dest_ip = '0;
  logic [7:0]  protocol = '0;
  logic        len_tvalid = 1'b0, len_tlast = 1'b0;
  logic [15:0] len_tdata = '0;
  logic        len_tready1, len_treadyw;
  logic        o1_tready = 1'b1, o1_tvalid, o1_tlast, len_err1;
  logic [7:0]  o1_tdata;
  logic        ow_tready = 1'b1, ow_tvalid, ow_tlast, len_errw;
  logic [31:0] ow_tdata;

  int n_checks = 0, n_pass = 0, cyc = 0, hs_cyc = 0, beats_done = 0;
  bit stall_en = 1'b0;
  logic [15:0] exp_id = ID0;
  logic [8:0]  exp_b[$];
  logic [32:0] exp_w[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ip_header_gen_wide #(.AXIS_BYTES(1), .ID_INIT(ID0)) dut1 (
    .clk(clk), .sresetn(sresetn), .src_ip(src_ip), .dest_ip(dest_ip), .protocol(protocol),
    .payload_length_axis_tready(len_tready1), .payload_length_axis_tvalid(len_tvalid),
    .payload_length_axis_tlast(len_tlast), .payload_length_axis_tdata(len_tdata),
    .axis_o_tready(o1_tready), .axis_o_tvalid(o1_tvalid), .axis_o_tlast(o1_tlast),
    .axis_o_tdata(o1_tdata), .len_err(len_err1));

  ip_header_gen_wide #(.AXIS_BYTES(4), .ID_INIT(ID0)) dutw (
    .clk(clk), .sresetn(sresetn), .src_ip(src_ip), .dest_ip(dest_ip), .protocol(protocol),
    .payload_length_axis_tready(len_treadyw), .payload_length_axis_tvalid(len_tvalid),
    .payload_length_axis_tlast(len_tlast), .payload_length_axis_tdata(len_tdata),
    .axis_o_tready(ow_tready), .axis_o_tvalid(ow_tvalid), .axis_o_tlast(ow_tlast),
    .axis_o_tdata(ow_tdata), .len_err(len_errw));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Ones'-complement accumulation with end-around carry after every word
  function automatic logic [159:0] model_hdr(input logic [15:0] tot, input logic [15:0] id,
                                             input logic [31:0] s, input logic [31:0] d,
                                             input logic [7:0] p);
    logic [159:0] h;
    logic [16:0]  acc17;
    logic [15:0]  a16;
    h   = {8'h45, 8'h00, tot, id, 16'h4000, 8'h40, p, 16'h0000, s, d};
    a16 = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      acc17 = {1'b0, a16} + {1'b0, h[159-16*i -: 16]};
      a16   = acc17[15:0] + {15'd0, acc17[16]};
    end
    h[79:64] = ~a16;
    return h;
  endfunction

  task automatic push_hdr(input logic [159:0] h);
    for (int k = 0; k < 20; k++) exp_b.push_back({(k == 19), h[159-8*k -: 8]});
    for (int k = 0; k < 5; k++)  exp_w.push_back({(k == 4), h[159-32*k -: 32]});
  endtask

  task automatic send(input logic [15:0] len, input logic [31:0] s, input logic [31:0] d,
                      input logic [7:0] p, input bit kv, input bit err);
    logic [159:0] h;
    int n = 0;
    @(posedge clk); #1;
    while (!(len_tready1 && len_treadyw)) begin
      if (n > 400) begin
        n_checks++;
        $display("FAIL len_tready_timeout: got 0 expected 1");
        return;
      end
      n++;
      @(posedge clk); #1;
    end
    src_ip = s; dest_ip = d; protocol = p; len_tdata = len; len_tvalid = 1'b1; len_tlast = 1'b1;
    @(posedge clk); #1;
    hs_cyc = cyc;
    len_tvalid = 1'b0; src_ip = ~s; dest_ip = ~d; protocol = ~p; len_tdata = 16'haaaa;
    if (err) begin
      @(negedge clk);
      check("len_err1_pulse", 64'(len_err1), 64'd1);
      check("len_errw_pulse", 64'(len_errw), 64'd1);
      @(negedge clk);
      check("len_err1_clear", 64'(len_err1), 64'd0);
      check("len_tready_back", 64'(len_tready1), 64'd1);
      check("no_tvalid_on_err", 64'(o1_tvalid), 64'd0);
    end else begin
      h = (kv && exp_id == 16'h0000) ? KV : model_hdr(len + 16'd20, exp_id, s, d, p);
      push_hdr(h);
`ifdef IP_HEADER_GEN_ID_COUNTER_EN
      exp_id = exp_id + 16'd1;
`endif
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_b.size() != 0 || exp_w.size() != 0) begin
      if (n > 2000) begin
        n_checks++;
        $display("FAIL drain_timeout: got %0d expected 0", exp_b.size() + exp_w.size());
        return;
      end
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    check("idle_tready", 64'(len_tready1), 64'd1);
  endtask

  // Ready generator for the byte-wide output
  initial begin
    forever begin
      @(posedge clk); #1;
      o1_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Byte-wide monitor: pops the scoreboard on every handshake, checks hold-while-stalled
  initial begin
    logic [8:0] e;
    logic [7:0] prev_d = '0;
    logic prev_l = 1'b0, prev_stall = 1'b0, prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (sresetn && prev_stall) begin
        check("stall_valid1", 64'(o1_tvalid), 64'd1);
        check("stall_data1", 64'(o1_tdata), 64'(prev_d));
        check("stall_last1", 64'(o1_tlast), 64'(prev_l));
      end
      if (sresetn && o1_tvalid && !prev_v) check("latency1", 64'(cyc - hs_cyc), 64'd2);
      if (sresetn && o1_tvalid && o1_tready) begin
        if (exp_b.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_beat1: got %0h expected none", o1_tdata);
        end else begin
          e = exp_b.pop_front();
          check("byte1", 64'(o1_tdata), 64'(e[7:0]));
          check("last1", 64'(o1_tlast), 64'(e[8]));
          beats_done++;
        end
      end
      prev_stall = sresetn && o1_tvalid && !o1_tready;
      prev_d = o1_tdata; prev_l = o1_tlast; prev_v = o1_tvalid;
    end
  end

  // Word-wide monitor
  initial begin
    logic [32:0] e;
    logic prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (sresetn && ow_tvalid && !prev_v) check("latencyw", 64'(cyc - hs_cyc), 64'd2);
      if (sresetn && ow_tvalid && ow_tready) begin
        if (exp_w.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_beatw: got %0h expected none", ow_tdata);
        end else begin
          e = exp_w.pop_front();
          check("wordw", 64'(ow_tdata), 64'(e[31:0]));
          check("lastw", 64'(ow_tlast), 64'(e[32]));
        end
      end
      prev_v = ow_tvalid;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_tready1", 64'(len_tready1), 64'd0);
    check("rst_tvalid1", 64'(o1_tvalid), 64'd0);
    check("rst_tlast1", 64'(o1_tlast), 64'd0);
    check("rst_tdata1", 64'(o1_tdata), 64'd0);
    check("rst_len_err1", 64'(len_err1), 64'd0);
    check("rst_tvalidw", 64'(ow_tvalid), 64'd0);
    check("rst_tdataw", 64'(ow_tdata), 64'd0);
    @(posedge clk); #1;
    sresetn = 1'b1;

    // Known vector, then the same request under random back-pressure (ID walk with counter)
    send(16'd95, 32'hc0a80001, 32'hc0a800c7, 8'h11, 1'b1, 1'b0);
    wait_drain();
    stall_en = 1'b1;
    send(16'd95, 32'hc0a80001, 32'hc0a800c7, 8'h11, 1'b1, 1'b0);
    send(16'd95, 32'hc0a80001, 32'hc0a800c7, 8'h11, 1'b1, 1'b0);
    wait_drain();
    stall_en = 1'b0;

    // Length boundaries, then a normal packet to confirm the ID did not move
    send(16'd65515, 32'h0a000001, 32'h0a0000fe, 8'h06, 1'b0, 1'b0);
    send(16'd65516, 32'h0a000001, 32'h0a0000fe, 8'h06, 1'b0, 1'b1);
    send(16'd0, 32'h0a000001, 32'h0a0000fe, 8'h06, 1'b0, 1'b0);
    wait_drain();

    // Abort mid-header after byte 7
    beats_done = 0;
    send(16'd200, 32'h01020304, 32'h05060708, 8'h11, 1'b0, 1'b0);
    n = 0;
    while (beats_done < 7 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    check("reached_beat7", 64'(beats_done), 64'd7);
    @(posedge clk); #1;
    sresetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_tvalid", 64'(o1_tvalid), 64'd0);
    check("abort_tlast", 64'(o1_tlast), 64'd0);
    check("abort_tdata", 64'(o1_tdata), 64'd0);
    check("abort_tready", 64'(len_tready1), 64'd0);
    exp_b.delete();
    exp_w.delete();
    exp_id = ID0;
    @(posedge clk); #1;
    sresetn = 1'b1;
    send(16'd95, 32'hc0a80001, 32'hc0a800c7, 8'h11, 1'b1, 1'b0);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
